lsu_mem_stage: RTL and testbench

//  Load/store unit for the pipeline MEM stage; sits between execute and dmemory.

---
 rtl/lsu_mem_stage.sv | 126 ++++++++++++
 tb/tb_lsu_mem_stage.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_stage.sv
// rtl/lsu_mem_stage.sv - MEM-stage load/store unit: dmemory issue, fault checks, extended writeback
// Results stay valid under writeback backpressure by capturing live read data into a hold register.
module lsu_mem_stage #(
  parameter logic [31:0] START_ADDR = 32'h0100_0000,
  parameter int unsigned MEM_DEPTH  = 1048576
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_is_load,
  input  logic        in_is_store,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_store_data,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_alu_result,
  output logic        dmem_read_write,
  output logic [31:0] dmem_address,
  output logic [1:0]  dmem_access_size,
  output logic [31:0] dmem_data_in,
  input  logic [31:0] dmem_data_out,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd,
  output logic        wb_we,
  output logic [31:0] wb_data,
  output logic        wb_fault,
  output logic [1:0]  wb_fault_cause
);
  localparam logic [32:0] END_ADDR = {1'b0, START_ADDR} + 33'(MEM_DEPTH);
  localparam logic [1:0] CAUSE_MISALIGNED = 2'd0;
  localparam logic [1:0] CAUSE_RANGE      = 2'd1;
  localparam logic [1:0] CAUSE_ILLEGAL    = 2'd2;

  typedef enum logic [1:0] {EMPTY, FRESH, HELD} state_t;

  state_t      state;
  logic        ld_live;
  logic [2:0]  ld_funct3;
  logic [31:0] data_r;

  logic        is_mem, illegal, misaligned, out_of_range, fault, accept;
  logic [1:0]  cause;
  logic [1:0]  size_m1;
  logic [32:0] last_byte;
  logic [31:0] load_ext;

  always_comb begin
    is_mem = in_is_load || in_is_store;
    case (in_funct3[1:0])
      2'b00:   size_m1 = 2'd0;
      2'b01:   size_m1 = 2'd1;
      default: size_m1 = 2'd3;
    endcase
    illegal = is_mem && ((in_funct3[1:0] == 2'b11) || (in_funct3[2] && in_funct3[1]) ||
                         (in_is_store && in_funct3[2]));
    misaligned = is_mem && (((in_funct3[1:0] == 2'b01) && in_addr[0]) ||
                            ((in_funct3[1:0] == 2'b10) && (in_addr[1:0] != 2'b00)));
    // 33-bit sum so an access straddling 2^32 cannot wrap back into range
    last_byte    = {1'b0, in_addr} + {31'b0, size_m1};
    out_of_range = is_mem && ((in_addr < START_ADDR) || (last_byte >= END_ADDR));
    fault        = illegal || misaligned || out_of_range;
    if (illegal)           cause = CAUSE_ILLEGAL;
    else if (misaligned)   cause = CAUSE_MISALIGNED;
    else if (out_of_range) cause = CAUSE_RANGE;
    else                   cause = 2'd0;
  end

  assign in_ready         = (state == EMPTY) || wb_ready;
  assign accept           = in_valid && in_ready;
  assign dmem_address     = in_addr;
  assign dmem_access_size = in_funct3[1:0];
  assign dmem_data_in     = in_store_data;
  assign dmem_read_write  = accept && in_is_store && !fault && !reset;

  always_comb begin
    case (ld_funct3)
      3'b000:  load_ext = {{24{dmem_data_out[7]}}, dmem_data_out[7:0]};
      3'b001:  load_ext = {{16{dmem_data_out[15]}}, dmem_data_out[15:0]};
      3'b100:  load_ext = {24'd0, dmem_data_out[7:0]};
      3'b101:  load_ext = {16'd0, dmem_data_out[15:0]};
      default: load_ext = dmem_data_out;
    endcase
  end

  // dmemory only returns this load's data in the cycle right after issue
  assign wb_data = ((state == FRESH) && ld_live) ? load_ext : data_r;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= EMPTY;
      wb_valid       <= 1'b0;
      wb_rd          <= 5'd0;
      wb_we          <= 1'b0;
      wb_fault       <= 1'b0;
      wb_fault_cause <= 2'd0;
      ld_live        <= 1'b0;
      ld_funct3      <= 3'd0;
      data_r         <= 32'd0;
    end else if (accept) begin
      state          <= FRESH;
      wb_valid       <= 1'b1;
      wb_rd          <= in_rd;
      wb_we          <= (in_is_load || !is_mem) && (in_rd != 5'd0) && !fault;
      wb_fault       <= fault;
      wb_fault_cause <= cause;
      ld_live        <= in_is_load && !fault;
      ld_funct3      <= in_funct3;
      data_r         <= is_mem ? 32'd0 : in_alu_result;
    end else if ((state != EMPTY) && wb_ready) begin
      state          <= EMPTY;
      wb_valid       <= 1'b0;
      wb_rd          <= 5'd0;
      wb_we          <= 1'b0;
      wb_fault       <= 1'b0;
      wb_fault_cause <= 2'd0;
      ld_live        <= 1'b0;
      data_r         <= 32'd0;
    end else if (state == FRESH) begin
      state   <= HELD;
      ld_live <= 1'b0;
      if (ld_live) data_r <= load_ext;
    end
  end
endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb/tb_lsu_mem_stage.sv - Self-checking bench for lsu_mem_stage with a byte-level memory reference
// A registered-read dmemory lives here; expected results come from a byte-map model of the ISA rules.
module tb_lsu_mem_stage;
  localparam logic [31:0] START = 32'h0100_0000;
  localparam longint      DEPTH = 1048576;
  localparam logic [31:0] ENDA  = 32'h0110_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_is_load, in_is_store;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr, in_store_data, in_alu_result;
  logic [4:0]  in_rd;
  logic        dmem_read_write;
  logic [31:0] dmem_address, dmem_data_in, dmem_data_out;
  logic [1:0]  dmem_access_size;
  logic        wb_valid, wb_ready, wb_we, wb_fault;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [1:0]  wb_fault_cause;

  lsu_mem_stage #(.START_ADDR(START), .MEM_DEPTH(1048576)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_is_load(in_is_load), .in_is_store(in_is_store), .in_funct3(in_funct3),
    .in_addr(in_addr), .in_store_data(in_store_data), .in_rd(in_rd),
    .in_alu_result(in_alu_result), .dmem_read_write(dmem_read_write),
    .dmem_address(dmem_address), .dmem_access_size(dmem_access_size),
    .dmem_data_in(dmem_data_in), .dmem_data_out(dmem_data_out),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_we(wb_we),
    .wb_data(wb_data), .wb_fault(wb_fault), .wb_fault_cause(wb_fault_cause)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [4:0]  rd;
    logic        we;
    logic        fault;
    logic [1:0]  cause;
    logic [31:0] data;
  } res_t;

  typedef struct packed {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic [31:0] alu;
  } req_t;

  int n_checks = 0;
  int n_errors = 0;

  // dmemory: 4 KiB window, registered read returning the full little-endian word at the address
  logic [7:0] dm [0:4095];
  logic       mem_clear;
  int         wr_count;

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  always @(posedge clock) begin
    if (mem_clear) begin
      for (int i = 0; i < 4096; i++) dm[i] <= 8'd0;
      wr_count <= 0;
    end else begin
      if (dmem_read_write) begin
        wr_count <= wr_count + 1;
        for (int i = 0; i < 4; i++)
          if (i < nbytes(dmem_access_size))
            dm[12'(dmem_address + 32'(i))] <= dmem_data_in[8*i +: 8];
      end
      dmem_data_out <= {dm[12'(dmem_address + 32'd3)], dm[12'(dmem_address + 32'd2)],
                        dm[12'(dmem_address + 32'd1)], dm[12'(dmem_address)]};
    end
  end

  // Reference: sparse byte map keyed by full address
  logic [7:0] ref_mem [int unsigned];

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'd0;
  endfunction

  function automatic res_t model(input req_t r, output logic wr);
    res_t   e;
    int     nb;
    bit     legal;
    longint v;
    e = '0;
    e.rd = r.rd;
    wr = 1'b0;
    if (!r.ld && !r.st) begin
      e.data = r.alu;
      e.we = (r.rd != 5'd0);
      return e;
    end
    nb = (r.f3[1:0] == 2'd0) ? 1 : (r.f3[1:0] == 2'd1) ? 2 : 4;
    legal = r.ld ? (r.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (r.f3 inside {3'd0, 3'd1, 3'd2});
    if (!legal) begin
      e.fault = 1'b1; e.cause = 2'd2;
    end else if ((r.addr % nb) != 0) begin
      e.fault = 1'b1; e.cause = 2'd0;
    end else if ((longint'(r.addr) < longint'(START)) ||
                 (longint'(r.addr) + nb > longint'(START) + DEPTH)) begin
      e.fault = 1'b1; e.cause = 2'd1;
    end
    if (e.fault) return e;
    if (r.st) begin
      for (int i = 0; i < nb; i++) ref_mem[r.addr + 32'(i)] = r.sd[8*i +: 8];
      wr = 1'b1;
    end else begin
      v = 0;
      for (int i = 0; i < nb; i++) v += longint'(ref_byte(r.addr + 32'(i))) << (8 * i);
      if (!r.f3[2] && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v -= (longint'(1) << (8 * nb));
      e.data = v[31:0];
      e.we = (r.rd != 5'd0);
    end
    return e;
  endfunction

  function automatic req_t mk(input logic ld, st, input logic [2:0] f3, input logic [31:0] a, sd,
                              input logic [4:0] rd, input logic [31:0] alu);
    return '{ld: ld, st: st, f3: f3, addr: a, sd: sd, rd: rd, alu: alu};
  endfunction

  task automatic drive(input req_t r, input logic v);
    in_valid = v; in_is_load = r.ld; in_is_store = r.st; in_funct3 = r.f3;
    in_addr = r.addr; in_store_data = r.sd; in_rd = r.rd; in_alu_result = r.alu;
  endtask

  function automatic res_t observe();
    return {wb_rd, wb_we, wb_fault, wb_fault_cause, wb_data};
  endfunction

  // One request with wb_ready=1; returns what the DUT showed on the issue cycle and the next cycle
  task automatic run_op(input req_t r, output res_t e, output res_t o, output logic e_wr,
                        output logic o_wr, output logic o_valid);
    @(negedge clock);
    wb_ready = 1'b1;
    drive(r, 1'b1);
    #1;
    o_wr = dmem_read_write;
    e = model(r, e_wr);
    @(negedge clock);
    in_valid = 1'b0;
    #1;
    o_valid = wb_valid;
    o = observe();
    if (e.fault) begin e.data = 32'd0; o.data = 32'd0; end
  endtask

  task automatic test_reset;
    reset = 1'b1; mem_clear = 1'b1; wb_ready = 1'b1;
    drive(mk(0, 1, 3'b010, START, 32'h1111_2222, 5'd0, 32'd0), 1'b1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      mem_clear = 1'b0;
      #1;
      n_checks++;
      if ({wb_valid, wb_we, wb_fault, wb_fault_cause, wb_rd, wb_data} !== '0) begin
        n_errors++;
        $display("FAIL reset_outputs: valid=%b we=%b fault=%b cause=%0d rd=%0d data=%h, want all 0",
                 wb_valid, wb_we, wb_fault, wb_fault_cause, wb_rd, wb_data);
      end
      n_checks++;
      if (dmem_read_write !== 1'b0) begin
        n_errors++; $display("FAIL reset_no_store: rw=%b want 0", dmem_read_write);
      end
    end
    @(negedge clock);
    reset = 1'b0; in_valid = 1'b0;
    #1;
    n_checks++;
    if (wr_count !== 0) begin n_errors++; $display("FAIL reset_wr_count: got %0d want 0", wr_count); end
  endtask

  task automatic check_op(input string name, input req_t r);
    res_t e, o; logic e_wr, o_wr, o_valid;
    run_op(r, e, o, e_wr, o_wr, o_valid);
    n_checks++;
    if (o_valid !== 1'b1) begin n_errors++; $display("FAIL %s_valid: got %b want 1", name, o_valid); end
    n_checks++;
    if (o_wr !== e_wr) begin n_errors++; $display("FAIL %s_rw: got %b want %b", name, o_wr, e_wr); end
    n_checks++;
    if (o !== e) begin n_errors++; $display("FAIL %s_result: got %h want %h", name, o, e); end
  endtask

  task automatic test_store_load;
    res_t e, o; logic e_wr, o_wr, o_valid;
    check_op("sw_deadbeef", mk(0, 1, 3'b010, START + 32'd4, 32'hDEAD_BEEF, 5'd0, 32'd0));
    run_op(mk(1, 0, 3'b010, START + 32'd4, 32'd0, 5'd3, 32'd0), e, o, e_wr, o_wr, o_valid);
    n_checks++;
    if (o_valid !== 1'b1 || o.data !== 32'hDEAD_BEEF || o.we !== 1'b1) begin
      n_errors++; $display("FAIL lw_deadbeef: valid=%b data=%h we=%b want 1 deadbeef 1", o_valid, o.data, o.we);
    end
  endtask

  task automatic test_byte;
    res_t e, o; logic e_wr, o_wr, o_valid;
    check_op("sb_80", mk(0, 1, 3'b000, START + 32'd1, 32'hABCD_EF80, 5'd0, 32'd0));
    run_op(mk(1, 0, 3'b000, START + 32'd1, 32'd0, 5'd5, 32'd0), e, o, e_wr, o_wr, o_valid);
    n_checks++;
    if (o.data !== 32'hFFFF_FF80) begin n_errors++; $display("FAIL lb_sign: got %h want ffffff80", o.data); end
    run_op(mk(1, 0, 3'b100, START + 32'd1, 32'd0, 5'd6, 32'd0), e, o, e_wr, o_wr, o_valid);
    n_checks++;
    if (o.data !== 32'h0000_0080) begin n_errors++; $display("FAIL lbu_zero: got %h want 00000080", o.data); end
    check_op("lw_neighbours", mk(1, 0, 3'b010, START, 32'd0, 5'd7, 32'd0));
    check_op("lh_sign", mk(1, 0, 3'b001, START, 32'd0, 5'd8, 32'd0));
    check_op("lhu_zero", mk(1, 0, 3'b101, START, 32'd0, 5'd9, 32'd0));
    check_op("lw_rd0", mk(1, 0, 3'b010, START + 32'd4, 32'd0, 5'd0, 32'd0));
  endtask

  task automatic test_passthrough;
    check_op("pass_rd9", mk(0, 0, 3'b000, 32'h0000_0003, 32'd0, 5'd9, 32'h1234_5678));
    check_op("pass_rd0", mk(0, 0, 3'b000, 32'hFFFF_FFFF, 32'd0, 5'd0, 32'hCAFE_F00D));
  endtask

  task automatic test_faults;
    req_t tbl [10];
    int w0;
    tbl[0] = mk(1, 0, 3'b001, START + 32'd3, 32'd0, 5'd1, 32'd0);
    tbl[1] = mk(0, 1, 3'b010, START - 32'd4, 32'h5555_AAAA, 5'd0, 32'd0);
    tbl[2] = mk(0, 1, 3'b100, START + 32'd8, 32'h77, 5'd0, 32'd0);
    tbl[3] = mk(1, 0, 3'b011, START + 32'd1, 32'd0, 5'd2, 32'd0);
    tbl[4] = mk(1, 0, 3'b010, ENDA - 32'd4, 32'd0, 5'd3, 32'd0);
    tbl[5] = mk(1, 0, 3'b001, ENDA - 32'd2, 32'd0, 5'd4, 32'd0);
    tbl[6] = mk(0, 1, 3'b001, ENDA - 32'd1, 32'h1, 5'd0, 32'd0);
    tbl[7] = mk(0, 1, 3'b000, ENDA, 32'h2, 5'd0, 32'd0);
    tbl[8] = mk(1, 0, 3'b110, START, 32'd0, 5'd5, 32'd0);
    tbl[9] = mk(1, 0, 3'b000, START - 32'd1, 32'd0, 5'd6, 32'd0);
    w0 = wr_count;
    for (int i = 0; i < 10; i++) check_op($sformatf("fault%0d", i), tbl[i]);
    n_checks++;
    if (wr_count !== w0) begin n_errors++; $display("FAIL fault_no_write: writes=%0d want %0d", wr_count, w0); end
  endtask

  task automatic test_stall;
    req_t ld, st;
    res_t e, e2;
    logic ewr;
    ld = mk(1, 0, 3'b010, START + 32'd4, 32'd0, 5'd10, 32'd0);
    st = mk(0, 1, 3'b010, START + 32'd8, $urandom, 5'd0, 32'd0);
    @(negedge clock);
    wb_ready = 1'b0;
    drive(ld, 1'b1);
    e = model(ld, ewr);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      drive(st, 1'b1);
      #1;
      n_checks++;
      if (wb_valid !== 1'b1 || wb_data !== e.data || in_ready !== 1'b0 || dmem_read_write !== 1'b0) begin
        n_errors++;
        $display("FAIL stall_hold%0d: valid=%b data=%h ready=%b rw=%b want 1 %h 0 0",
                 k, wb_valid, wb_data, in_ready, dmem_read_write, e.data);
      end
    end
    @(negedge clock);
    wb_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || wb_data !== e.data || dmem_read_write !== 1'b1) begin
      n_errors++;
      $display("FAIL stall_release: ready=%b data=%h rw=%b want 1 %h 1", in_ready, wb_data, dmem_read_write, e.data);
    end
    e2 = model(st, ewr);
    @(negedge clock);
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (observe() !== e2 || wb_valid !== 1'b1) begin
      n_errors++; $display("FAIL stall_next_store: got %h valid=%b want %h", observe(), wb_valid, e2);
    end
    check_op("stall_readback", mk(1, 0, 3'b010, START + 32'd8, 32'd0, 5'd11, 32'd0));
  endtask

  task automatic test_back_to_back;
    res_t q[$];
    res_t e;
    logic ewr;
    req_t r;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      wb_ready = 1'b1;
      if (k < 4) begin
        r = mk(1, 0, 3'(k % 2 == 0 ? 2 : 0), START + 32'(4 * k), 32'd0, 5'(12 + k), 32'd0);
        drive(r, 1'b1);
        q.push_back(model(r, ewr));
      end else in_valid = 1'b0;
      #1;
      if (k < 4) begin
        n_checks++;
        if (in_ready !== 1'b1) begin n_errors++; $display("FAIL b2b_ready%0d: got %b want 1", k, in_ready); end
      end
      if (k > 0) begin
        e = q.pop_front();
        n_checks++;
        if (wb_valid !== 1'b1 || observe() !== e) begin
          n_errors++; $display("FAIL b2b_result%0d: valid=%b got %h want %h", k - 1, wb_valid, observe(), e);
        end
      end
    end
    @(negedge clock);
    #1;
    n_checks++;
    if (wb_valid !== 1'b0) begin n_errors++; $display("FAIL b2b_drain: valid=%b want 0", wb_valid); end
  endtask

  task automatic test_reset_held;
    int w0;
    @(negedge clock);
    wb_ready = 1'b0;
    drive(mk(1, 0, 3'b010, START + 32'd4, 32'd0, 5'd20, 32'd0), 1'b1);
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    #1;
    n_checks++;
    if (wb_valid !== 1'b1) begin n_errors++; $display("FAIL held_before_reset: valid=%b want 1", wb_valid); end
    @(negedge clock);
    w0 = wr_count;
    wb_ready = 1'b1;
    drive(mk(0, 1, 3'b010, START + 32'd16, 32'h1234_5678, 5'd0, 32'd0), 1'b1);
    reset = 1'b1;
    #1;
    n_checks++;
    if (dmem_read_write !== 1'b0) begin n_errors++; $display("FAIL reset_held_rw: got %b want 0", dmem_read_write); end
    @(negedge clock);
    #1;
    n_checks++;
    if (wb_valid !== 1'b0 || wb_data !== 32'd0 || wr_count !== w0) begin
      n_errors++; $display("FAIL reset_held_drop: valid=%b data=%h writes=%0d want 0 0 %0d", wb_valid, wb_data, wr_count, w0);
    end
    reset = 1'b0;
    in_valid = 1'b0;
    check_op("reset_held_nowrite", mk(1, 0, 3'b010, START + 32'd16, 32'd0, 5'd21, 32'd0));
  endtask

  task automatic test_random;
    res_t q[$];
    res_t e, o;
    logic ewr;
    req_t r;
    int kind;
    logic [2:0] lf [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    for (int i = 0; i < 420; i++) begin
      @(negedge clock);
      wb_ready = (i >= 400) || ($urandom_range(0, 3) != 0);
      kind = $urandom_range(0, 9);
      r = mk(kind < 4, kind >= 4 && kind < 8, 3'd0, $urandom, $urandom, 5'($urandom), $urandom);
      if (r.ld || r.st) begin
        if ($urandom_range(0, 7) == 0) r.f3 = 3'($urandom_range(0, 7));
        else r.f3 = r.ld ? lf[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
        case ($urandom_range(0, 9))
          0:       r.addr = START - 32'($urandom_range(1, 4));
          1:       r.addr = ENDA - 32'($urandom_range(1, 8));
          2:       r.addr = ENDA + 32'($urandom_range(0, 3));
          default: r.addr = START + 32'($urandom_range(0, 63));
        endcase
      end
      drive(r, (i < 400) && ($urandom_range(0, 3) != 0));
      #1;
      if (wb_valid && wb_ready) begin
        n_checks++;
        if (q.size() == 0) begin
          n_errors++; $display("FAIL rand_extra: unexpected result %h at cycle %0d", observe(), i);
        end else begin
          e = q.pop_front();
          o = observe();
          if (e.fault) begin e.data = 32'd0; o.data = 32'd0; end
          if (o !== e) begin n_errors++; $display("FAIL rand_result: cycle %0d got %h want %h", i, o, e); end
        end
      end
      n_checks++;
      if (in_valid && in_ready) begin
        q.push_back(model(r, ewr));
        if (dmem_read_write !== ewr) begin
          n_errors++; $display("FAIL rand_rw: cycle %0d got %b want %b", i, dmem_read_write, ewr);
        end
      end else if (dmem_read_write !== 1'b0) begin
        n_errors++; $display("FAIL rand_rw_idle: cycle %0d got %b want 0", i, dmem_read_write);
      end
    end
    n_checks++;
    if (q.size() != 0) begin n_errors++; $display("FAIL rand_drain: %0d results never retired", q.size()); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte();
    test_passthrough();
    test_faults();
    test_stall();
    test_back_to_back();
    test_reset_held();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
